// File: rtl/filter_run_ctrl_pkg.sv
// filter_run_ctrl shared definitions
// state codes, display modes, status word layout
package filter_run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  localparam logic [1:0] MODE_RESULT = 2'd0;
  localparam logic [1:0] MODE_PARAMS = 2'd1;
  localparam logic [1:0] MODE_COUNT  = 2'd2;
  localparam logic [1:0] MODE_STATUS = 2'd3;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_ERR_BIT   = 1;
  localparam int STAT_STATE_LSB = 4;

  // low byte of the status display word
  function automatic logic [7:0] status_byte(
    run_state_t s,
    logic       err,
    logic       busy
  );
    logic [7:0] b;
    b = '0;
    b[STAT_STATE_LSB +: 3] = s;
    b[STAT_ERR_BIT]        = err;
    b[STAT_BUSY_BIT]       = busy;
    return b;
  endfunction

endpackage

// File: rtl/filter_run_ctrl_btn_debounce.sv
// btn_debounce: two-flop sync, stability counter,
// one-cycle press pulse on debounced rising edge
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  // sync raw input, accept a new level once stable long enough
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/filter_run_ctrl.sv
// filter_run_ctrl: launches the filter core on a button
// press, times the run and feeds the display
import filter_run_ctrl_pkg::*;

module filter_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int WORD            = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_btn,
  input  logic [1:0]      mode_sw,
  input  logic            core_done,
  input  logic [WORD-1:0] core_result,
  input  logic [WORD-1:0] core_params,
  output logic            core_start,
  output logic [WORD-1:0] disp_value,
  output logic            busy_led,
  output logic            error_led,
  output logic [WORD-1:0] cycle_count
);

  localparam logic [WORD-1:0] TO_LAST =
    WORD'(TIMEOUT_CYCLES - 1);

  run_state_t      state;
  run_state_t      state_d;
  logic            press;
  logic            btn_level_unused;
  logic            timeout_hit;
  logic [WORD-1:0] result_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .raw  (start_btn),
    .level(btn_level_unused),
    .press(press)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (cycle_count == TO_LAST);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // next state; done wins over timeout
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE, TIMEOUT: if (press) state_d = LAUNCH;
      LAUNCH:              state_d = RUN;
      RUN: begin
        if (core_done)        state_d = DONE;
        else if (timeout_hit) state_d = TIMEOUT;
      end
      default:             state_d = IDLE;
    endcase
  end

  // run outputs, aligned with the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_start  <= 1'b0;
      busy_led    <= 1'b0;
      error_led   <= 1'b0;
      cycle_count <= '0;
      result_q    <= '0;
    end else begin
      core_start <= (state_d == LAUNCH);
      busy_led   <= (state_d == LAUNCH) || (state_d == RUN);
      if (state_d == LAUNCH) begin
        cycle_count <= '0;
        error_led   <= 1'b0;
      end else if (state == RUN) begin
        if (state_d == RUN && cycle_count != '1)
          cycle_count <= cycle_count + WORD'(1);
        if (state_d == TIMEOUT)
          error_led <= 1'b1;
        if (state_d == DONE)
          result_q <= core_result;
      end
    end
  end

  // display select, one cycle behind its sources
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_value <= '0;
    end else begin
      unique case (mode_sw)
        MODE_RESULT: disp_value <= result_q;
        MODE_PARAMS: disp_value <= core_params;
        MODE_COUNT:  disp_value <= cycle_count;
        MODE_STATUS: disp_value <= {{(WORD-8){1'b0}},
          status_byte(state, error_led, busy_led)};
        default:     disp_value <= result_q;
      endcase
    end
  end

endmodule

// File: doc/filter_run_ctrl.md
Name: filter_run_ctrl

Overview:
- Run controller between the board inputs and the RISC-V filter core.
- Debounces the raw start button and issues a single start pulse to the core. Waits for the core's done flag and times the run in clock cycles.
- Latches the result and cycle count. Selects which 32-bit word feeds the eight seven-segment digits.
- Drives busy and error LEDs.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before the debounced button level changes (sim value 4; board value 1000000)
TIMEOUT_CYCLES, 4096, run-cycle limit before abort; 0 disables the timeout
WORD, 32, width of result, parameter and display words

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start_btn  in  1  raw, asynchronous push button
mode_sw  in  2  display select
core_done  in  1  level from core, high when filter run complete
core_result  in  WORD  core output register (a0)
core_params  in  WORD  core parameter word
core_start  out  1  one-cycle start pulse to core
disp_value  out  WORD  word for seven-segment decoders
busy_led  out  1  high while run in progress
error_led  out  1  high after timeout, until next launch
cycle_count  out  WORD  cycles of last/current run

Behaviour:
- Reset: one clock; reset is asynchronous and active-high, port names clk and rst.
  - Asserting rst at any time, including mid-run, forces IDLE.
  - All outputs go to 0: core_start, busy_led, error_led, cycle_count, disp_value, latched result, debounce counter, debounced level, sync flops.
- Input sync: start_btn passes through two flops (sync1, sync2).
- Debounce:
  - Counter runs while sync2 != db_level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, db_level takes sync2 on that edge and the counter clears.
  - press is registered high for exactly one cycle, on the cycle after db_level rises 0->1.
  - Falling edges produce no press.
- FSM states: IDLE, LAUNCH, RUN, DONE, TIMEOUT.
  - IDLE/DONE/TIMEOUT + press -> LAUNCH. Otherwise hold.
  - LAUNCH (1 cycle):
    - core_start=1, cycle_count<=0, error_led<=0.
    - core_done is ignored.
    - Next state RUN.
  - RUN:
    - cycle_count increments by 1 per cycle.
    - press is ignored.
    - If core_done=1: latch core_result into result_q, freeze cycle_count, go DONE. done is checked before the timeout.
    - Else if TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1: go TIMEOUT, error_led<=1, cycle_count frozen.
    - core_done and the timeout condition in the same cycle -> DONE.
  - DONE / TIMEOUT: hold outputs until press or reset.
- cycle_count saturates at all-ones; it never wraps.
- busy_led = 1 exactly in LAUNCH and RUN, registered from state.
- core_start is high only in LAUNCH, so a run yields exactly one pulse per press.
- Display (registered, 1-cycle latency from mode_sw or source change):
  - 00: result_q
  - 01: core_params
  - 10: cycle_count
  - 11: status word = {24'b0, 1'b0, state[2:0], 2'b0, error_led, busy_led}
  - State encoding: IDLE=0, LAUNCH=1, RUN=2, DONE=3, TIMEOUT=4.
- Press-to-core_start latency after a clean raw edge: 2 sync + DEBOUNCE_CYCLES + 1 (press reg) + 1 (LAUNCH entry) cycles.

Decomposition:
- Shared package holds:
  - state enum codes (IDLE..TIMEOUT, 3 bits)
  - display mode constants (MODE_RESULT=0, MODE_PARAMS=1, MODE_COUNT=2, MODE_STATUS=3)
  - status word bit positions
- One sub-module, btn_debounce (sync + counter + rising-edge pulse), parameterized by DEBOUNCE_CYCLES, with clk/rst/raw in and level/press out. It is reusable for other board buttons.

Test Plan:
- Reset mid-RUN at cycle 5 -> all outputs 0 within the same cycle (async); state IDLE; no core_start after release until a new press.
- Debounce (DEBOUNCE_CYCLES=4): start_btn bounces 1,0,1,0 one cycle each, then held high 10 cycles -> exactly one core_start pulse, 2+4+1+1=8 cycles after the final rising raw edge; no pulse on release.
- Normal run: press; core_done asserted 12 cycles after core_start with core_result=0x0000_00A5 -> DONE; mode_sw=00 gives disp_value=0x0000_00A5; mode_sw=10 gives 12 (±1, per counting convention checked against spec: count equals RUN cycles before done); busy_led falls on DONE entry.
- Timeout (TIMEOUT_CYCLES=20): press, core_done never asserted -> TIMEOUT after 20 RUN cycles; error_led=1; cycle_count=19; mode_sw=11 gives 0x0000_0042; a new press clears error_led in LAUNCH.
- Simultaneous: core_done high on the cycle cycle_count==19 -> DONE, error_led=0, result latched.
- Press during RUN -> ignored: no second core_start, cycle_count continues. mode_sw=01 with core_params=0x1234_5678 -> disp_value=0x1234_5678 one cycle later.
